// File: rtl/acc_loader.sv
// Feeder for the accumulator: filters and buffers (opCode, value) words, streams them
// in load mode, then drains and drives calculate mode for a programmed number of cycles.
module acc_loader #(
  parameter int DEPTH    = 8,
  parameter int CAPACITY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opCode,
  input  logic [3:0] in_value,
  input  logic       go,
  input  logic [7:0] run_len,
  input  logic       cacheFull,
  output logic       mode,
  output logic [2:0] opCode,
  output logic [3:0] value,
  output logic [5:0] loaded_cnt,
  output logic [5:0] rejected_cnt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
  localparam logic [6:0]    CAP_L   = 7'(CAPACITY);
  localparam logic [2:0]    NOP_OP  = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [5:0]      loaded_q, loaded_d, rejected_q, rejected_d;
  logic [7:0]      run_len_q, run_len_d, run_cnt_q, run_cnt_d;
  logic            mode_q, mode_d, err_q, err_d;
  logic [2:0]      opcode_q, opcode_d;
  logic [3:0]      value_q, value_d;
  logic [6:0]      pending;
  logic            xfer, legal, push, pop;

  // Words already issued plus words still buffered must never exceed the downstream cache.
  assign pending  = {1'b0, loaded_q} + 7'(count_q);
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) &&
                    (count_q < DEPTH_L) && (pending < CAP_L);

  assign xfer  = in_valid && in_ready;
  assign legal = (in_opCode[1:0] != 2'b11);
  assign push  = xfer && legal;
  assign pop   = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && (count_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    loaded_d   = loaded_q;
    rejected_d = rejected_q;
    run_len_d  = run_len_q;
    run_cnt_d  = run_cnt_q;
    opcode_d   = NOP_OP;
    value_d    = 4'd0;
    mode_d     = 1'b0;
    err_d      = err_q | cacheFull;
    count_d    = count_q + CW'(push) - CW'(pop);

    if (xfer && !legal && (rejected_q != 6'd63)) rejected_d = rejected_q + 6'd1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d              = rd_ptr_q + 1'b1;
      loaded_d              = loaded_q + 6'd1;
      {opcode_d, value_d}   = mem_q[rd_ptr_q];
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d   = S_DRAIN;
          run_len_d = run_len;
        end else if (xfer) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (go) begin
          state_d   = S_DRAIN;
          run_len_d = run_len;
        end
      end
      S_DRAIN: begin
        // Leave only once the last popped word has had its own load-mode cycle.
        if (count_q == '0) begin
          if (run_len_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RUN;
            run_cnt_d = run_len_q;
          end
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q - 8'd1;
        if (run_cnt_q <= 8'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    mode_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      loaded_q   <= '0;
      rejected_q <= '0;
      run_len_q  <= '0;
      run_cnt_q  <= '0;
      mode_q     <= 1'b0;
      opcode_q   <= NOP_OP;
      value_q    <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      loaded_q   <= loaded_d;
      rejected_q <= rejected_d;
      run_len_q  <= run_len_d;
      run_cnt_q  <= run_cnt_d;
      mode_q     <= mode_d;
      opcode_q   <= opcode_d;
      value_q    <= value_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_opCode, in_value};
  end

  assign mode         = mode_q;
  assign opCode       = opcode_q;
  assign value        = value_q;
  assign loaded_cnt   = loaded_q;
  assign rejected_cnt = rejected_q;
  assign busy         = (state_q == S_DRAIN) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;

endmodule
